// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared types for the per-slave-port AHB arbiter: transfer types and arbiter FSM states.
// Optional bus locking is enabled with AHB_ARB_LOCK_EN (see ahb_slave_arbiter.sv).
package ahb_slave_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_type;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_OWN  = 1'b1
   } arb_state_type;

   // True for transfers that move data (and therefore count as a beat).
   function automatic logic is_xfer(input htrans_type t);
      return (t == NONSEQ) || (t == SEQ);
   endfunction

endpackage

// File: rtl/ahb_slave_arbiter_if.sv
// Slave-port arbitration bundle: master-side requests in, grant and mux selects out.
// The hlock vector exists only when AHB_ARB_LOCK_EN is defined.
interface ahb_slave_arbiter_if
   import ahb_slave_arbiter_pkg::*;
#(
   parameter int unsigned SLAVE_X_MASTER_NUM = 4
) ();

   localparam int unsigned SEL_WIDTH = $clog2(SLAVE_X_MASTER_NUM);

   logic [SLAVE_X_MASTER_NUM-1:0] hreq;
   htrans_type                    htrans_sel;
   logic                          hready;
   logic [SLAVE_X_MASTER_NUM-1:0] hgrant;
   logic [SEL_WIDTH-1:0]          hmaster_sel;
   logic [SEL_WIDTH-1:0]          hmaster_data_sel;
   logic                          hsel_slv;

`ifdef AHB_ARB_LOCK_EN
   logic [SLAVE_X_MASTER_NUM-1:0] hlock;

   modport slave (
      input  hreq, htrans_sel, hready, hlock,
      output hgrant, hmaster_sel, hmaster_data_sel, hsel_slv
   );

   modport master (
      output hreq, htrans_sel, hready, hlock,
      input  hgrant, hmaster_sel, hmaster_data_sel, hsel_slv
   );
`else
   modport slave (
      input  hreq, htrans_sel, hready,
      output hgrant, hmaster_sel, hmaster_data_sel, hsel_slv
   );

   modport master (
      output hreq, htrans_sel, hready,
      input  hgrant, hmaster_sel, hmaster_data_sel, hsel_slv
   );
`endif

endinterface

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: first unmasked request strictly after ptr, wrapping.
// Uses a doubled request vector so the wrap is a plain linear search.
module ahb_rr_picker #(
   parameter int unsigned N  = 4,
   parameter int unsigned SW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   input  logic [N-1:0]  mask,
   output logic [N-1:0]  grant,
   output logic [SW-1:0] index,
   output logic          valid
);

   localparam int unsigned PW = $clog2(2 * N);

   logic [2*N-1:0] dbl;
   logic [PW-1:0]  start;
   logic [PW-1:0]  pos;

   always_comb begin
      dbl   = {req & ~mask, req & ~mask};
      start = (ptr == SW'(N - 1)) ? '0 : (PW'(ptr) + PW'(1));
      valid = 1'b0;
      index = '0;
      grant = '0;
      pos   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         pos = start + PW'(i);
         if (!valid && dbl[pos]) begin
            valid = 1'b1;
            index = (pos >= PW'(N)) ? SW'(pos - PW'(N)) : SW'(pos);
         end
      end
      if (valid) grant[index] = 1'b1;
   end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave-port round-robin arbiter with transfer-boundary handover and a burst beat cap.
// Define AHB_ARB_LOCK_EN to add hlock, which pins the grant to a locking owner.
module ahb_slave_arbiter
   import ahb_slave_arbiter_pkg::*;
#(
   parameter int unsigned SLAVE_X_MASTER_NUM = 4,
   parameter int unsigned MAX_BURST_BEATS    = 16
) (
   input logic               hclk,
   input logic               hreset_n,
   ahb_slave_arbiter_if.slave bus
);

   localparam int unsigned N         = SLAVE_X_MASTER_NUM;
   localparam int unsigned SEL_WIDTH = $clog2(N);
   localparam int unsigned CNT_WIDTH = $clog2(MAX_BURST_BEATS + 1);

   arb_state_type        state_q;
   logic [SEL_WIDTH-1:0] rr_ptr_q;
   logic [CNT_WIDTH-1:0] beat_cnt_q;
   logic [N-1:0]         hgrant_q;
   logic [SEL_WIDTH-1:0] hmaster_sel_q;
   logic [SEL_WIDTH-1:0] hmaster_data_sel_q;

   logic                 xfer;
   logic                 owner_req;
   logic                 trans_idle;
   logic                 cap_hit;
   logic                 locked;
   logic                 arb_point;
   logic                 count_beat;
   logic [N-1:0]         pick_mask;
   logic [N-1:0]         pick_grant;
   logic [SEL_WIDTH-1:0] pick_index;
   logic                 pick_valid;

   // Arbitration-point decode for the current owner.
   always_comb begin
      xfer       = is_xfer(bus.htrans_sel);
      owner_req  = bus.hreq[hmaster_sel_q];
      trans_idle = (bus.htrans_sel == IDLE);
      cap_hit    = (bus.htrans_sel == NONSEQ) && (beat_cnt_q >= CNT_WIDTH'(MAX_BURST_BEATS));
`ifdef AHB_ARB_LOCK_EN
      locked     = bus.hlock[hmaster_sel_q];
`else
      locked     = 1'b0;
`endif
      arb_point  = (state_q == ARB_OWN) && bus.hready && !locked &&
                   (trans_idle || !owner_req || cap_hit);
      count_beat = bus.hready && xfer && (beat_cnt_q < CNT_WIDTH'(MAX_BURST_BEATS));
      // Owner stays eligible (last in RR order) only when it went IDLE.
      pick_mask  = '0;
      if ((state_q == ARB_OWN) && (!owner_req || cap_hit)) pick_mask = hgrant_q;
   end

   ahb_rr_picker #(
      .N  (N),
      .SW (SEL_WIDTH)
   ) u_picker (
      .req   (bus.hreq),
      .ptr   (rr_ptr_q),
      .mask  (pick_mask),
      .grant (pick_grant),
      .index (pick_index),
      .valid (pick_valid)
   );

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state_q            <= ARB_IDLE;
         rr_ptr_q           <= SEL_WIDTH'(N - 1);
         beat_cnt_q         <= '0;
         hgrant_q           <= '0;
         hmaster_sel_q      <= '0;
         hmaster_data_sel_q <= '0;
      end else begin
         if (bus.hready) hmaster_data_sel_q <= hmaster_sel_q;
         case (state_q)
            ARB_IDLE: begin
               if (pick_valid) begin
                  state_q       <= ARB_OWN;
                  hgrant_q      <= pick_grant;
                  hmaster_sel_q <= pick_index;
                  rr_ptr_q      <= pick_index;
                  beat_cnt_q    <= '0;
               end
            end
            ARB_OWN: begin
               if (arb_point) begin
                  if (pick_valid) begin
                     hgrant_q      <= pick_grant;
                     hmaster_sel_q <= pick_index;
                     rr_ptr_q      <= pick_index;
                     beat_cnt_q    <= '0;
                  end else if (cap_hit && owner_req) begin
                     // Capped owner is alone: it keeps the bus with a fresh budget.
                     beat_cnt_q <= '0;
                  end else begin
                     state_q    <= ARB_IDLE;
                     hgrant_q   <= '0;
                     beat_cnt_q <= '0;
                  end
               end else if (count_beat) begin
                  beat_cnt_q <= beat_cnt_q + CNT_WIDTH'(1);
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign bus.hgrant           = hgrant_q;
   assign bus.hmaster_sel      = hmaster_sel_q;
   assign bus.hmaster_data_sel = hmaster_data_sel_q;
   assign bus.hsel_slv         = (state_q == ARB_OWN) && xfer;

   a_grant_onehot: assert property (@(posedge hclk) disable iff (!hreset_n)
      $onehot0(hgrant_q));

   a_sel_matches_grant: assert property (@(posedge hclk) disable iff (!hreset_n)
      (|hgrant_q) |-> hgrant_q[hmaster_sel_q]);

endmodule
